// File: rtl/adder_tree_sequencer.sv
// adder_tree_sequencer
//
// Purpose: streams chunks of NUMBER_OF_ADDENDS signed addends into an external
// combinational adder tree and accumulates the per-chunk tree sums into a
// signed job total. A job is a programmable number of chunks. The total and a
// sticky overflow flag are offered through a valid/ready result handshake.
//
// Ports:
//   clk_in, rst_n_in      clock, asynchronous active-low reset
//   start_in              request a new job (honoured only in IDLE)
//   num_chunks_in         chunk count of the job, sampled with start_in
//   busy_out              high whenever the sequencer is not IDLE
//   chunk_valid_in        chunk handshake, producer side
//   chunk_ready_out       chunk handshake, high only in RUN
//   chunk_data_in         one chunk of packed addends
//   tree_addends_out      registered chunk feeding the external adder tree
//   tree_sum_in           signed tree sum of tree_addends_out (same cycle)
//   result_valid_out      result handshake, high only in DONE
//   result_ready_in       result handshake, consumer side
//   result_out            signed job total
//   overflow_out          sticky per-job accumulator overflow flag
//
// Configuration macro: ADDER_TREE_SATURATE_EN
//   undefined - an overflowing accumulate wraps modulo 2^ACC_WIDTH
//   defined   - an overflowing accumulate clamps to the most positive or most
//               negative ACC_WIDTH value and continues from there

module adder_tree_sequencer #(
    parameter int ADDEND_WIDTH      = 16,
    parameter int NUMBER_OF_ADDENDS = 64,
    parameter int SUM_WIDTH         = ADDEND_WIDTH + $clog2(NUMBER_OF_ADDENDS),
    parameter int ACC_WIDTH         = 32,
    parameter int CHUNK_CNT_WIDTH   = 8
) (
    input  logic                                      clk_in,
    input  logic                                      rst_n_in,
    input  logic                                      start_in,
    input  logic [CHUNK_CNT_WIDTH-1:0]                num_chunks_in,
    output logic                                      busy_out,
    input  logic                                      chunk_valid_in,
    output logic                                      chunk_ready_out,
    input  logic [NUMBER_OF_ADDENDS*ADDEND_WIDTH-1:0] chunk_data_in,
    output logic [NUMBER_OF_ADDENDS*ADDEND_WIDTH-1:0] tree_addends_out,
    input  logic [SUM_WIDTH-1:0]                      tree_sum_in,
    output logic                                      result_valid_out,
    input  logic                                      result_ready_in,
    output logic [ACC_WIDTH-1:0]                      result_out,
    output logic                                      overflow_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                                    r_state;
    state_t                                    w_next_state;
    logic [CHUNK_CNT_WIDTH-1:0]                r_remaining;
    logic [ACC_WIDTH-1:0]                      r_acc;
    logic                                      r_overflow;
    logic                                      r_acc_pending;
    logic [NUMBER_OF_ADDENDS*ADDEND_WIDTH-1:0] r_addends;

    logic                                      w_start;
    logic                                      w_xfer;
    logic                                      w_last;
    logic signed [ACC_WIDTH:0]                 w_sum_wide;
    logic                                      w_acc_ovf;
    logic [ACC_WIDTH-1:0]                      w_acc_next;

    assign w_start = (r_state == IDLE) && start_in;
    assign w_xfer  = (r_state == RUN) && chunk_valid_in;
    assign w_last  = (r_remaining == CHUNK_CNT_WIDTH'(1));

    // One extra bit of headroom: the two top bits disagree exactly when the
    // ACC_WIDTH-bit signed sum has overflowed, and the top bit is the true sign.
    assign w_sum_wide = (ACC_WIDTH+1)'($signed(r_acc)) + (ACC_WIDTH+1)'($signed(tree_sum_in));
    assign w_acc_ovf  = w_sum_wide[ACC_WIDTH] != w_sum_wide[ACC_WIDTH-1];

`ifdef ADDER_TREE_SATURATE_EN
    always_comb begin
        w_acc_next = w_sum_wide[ACC_WIDTH-1:0];
        if (w_acc_ovf) begin
            w_acc_next = w_sum_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                               : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
    end
`else
    assign w_acc_next = w_sum_wide[ACC_WIDTH-1:0];
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        busy_out         = (r_state != IDLE);
        chunk_ready_out  = (r_state == RUN);
        result_valid_out = (r_state == DONE);
        unique case (r_state)
            IDLE:    if (start_in) w_next_state = (num_chunks_in == '0) ? DONE : RUN;
            RUN:     if (w_xfer && w_last) w_next_state = DRAIN;
            DRAIN:   w_next_state = DONE;
            DONE:    if (result_ready_in) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // The tree sum of a registered chunk is only available the cycle after its
    // transfer, so r_acc_pending delays the accumulate by one edge. Gap cycles
    // leave it low and therefore add nothing.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_remaining   <= '0;
            r_acc         <= '0;
            r_overflow    <= 1'b0;
            r_acc_pending <= 1'b0;
            r_addends     <= '0;
        end else begin
            r_acc_pending <= w_xfer;
            if (w_start) begin
                r_remaining <= num_chunks_in;
                r_acc       <= '0;
                r_overflow  <= 1'b0;
            end else begin
                if (w_xfer) begin
                    r_addends   <= chunk_data_in;
                    r_remaining <= r_remaining - CHUNK_CNT_WIDTH'(1);
                end
                if (r_acc_pending) begin
                    r_acc <= w_acc_next;
                    if (w_acc_ovf) begin
                        r_overflow <= 1'b1;
                    end
                end
            end
        end
    end

    assign tree_addends_out = r_addends;
    assign result_out       = r_acc;
    assign overflow_out     = r_overflow;

endmodule

// File: tb/tb_adder_tree_sequencer.sv
// tb_adder_tree_sequencer
//
// Purpose: drives adder_tree_sequencer with directed and random jobs, models
// the external adder tree, and compares results with a job-level model that
// sums each chunk arithmetically and applies wrap or saturation per chunk.
// The accumulator is narrowed to 22 bits so that overflow is reachable.

module tb_adder_tree_sequencer;

    localparam int AW   = 16;
    localparam int N    = 64;
    localparam int SW   = AW + $clog2(N);
    localparam int ACCW = 22;
    localparam int CW   = 8;

    localparam longint ACC_MAX  = (longint'(1) <<< (ACCW-1)) - 1;
    localparam longint ACC_MIN  = -(longint'(1) <<< (ACCW-1));
    localparam longint ACC_SPAN = longint'(1) <<< ACCW;

    logic            clock          = 1'b0;
    logic            resetN         = 1'b0;
    logic            startIn        = 1'b0;
    logic [CW-1:0]   numChunksIn    = '0;
    logic            busyOut;
    logic            chunkValidIn   = 1'b0;
    logic            chunkReadyOut;
    logic [N*AW-1:0] chunkDataIn    = '0;
    logic [N*AW-1:0] treeAddendsOut;
    logic [SW-1:0]   treeSum;
    logic            resultValidOut;
    logic            resultReadyIn  = 1'b0;
    logic [ACCW-1:0] resultOut;
    logic            overflowOut;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    // Stand-in for the external combinational adder tree.
    always_comb begin
        treeSum = '0;
        for (int i = 0; i < N; i++) begin
            treeSum = treeSum + SW'($signed(treeAddendsOut[i*AW +: AW]));
        end
    end

    adder_tree_sequencer #(
        .ADDEND_WIDTH     (AW),
        .NUMBER_OF_ADDENDS(N),
        .SUM_WIDTH        (SW),
        .ACC_WIDTH        (ACCW),
        .CHUNK_CNT_WIDTH  (CW)
    ) dut (
        .clk_in          (clock),
        .rst_n_in        (resetN),
        .start_in        (startIn),
        .num_chunks_in   (numChunksIn),
        .busy_out        (busyOut),
        .chunk_valid_in  (chunkValidIn),
        .chunk_ready_out (chunkReadyOut),
        .chunk_data_in   (chunkDataIn),
        .tree_addends_out(treeAddendsOut),
        .tree_sum_in     (treeSum),
        .result_valid_out(resultValidOut),
        .result_ready_in (resultReadyIn),
        .result_out      (resultOut),
        .overflow_out    (overflowOut)
    );

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        vectors++;
        if (observed != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Runs one complete job. gapMode: 0 back-to-back, 1 idle cycle after every
    // chunk, 2 random idle cycles. During the result wait, start is pulsed once
    // when holdCycles > 2 and must be ignored.
    task automatic applyStimulus(input int nChunks, input bit randomFill, input int fillValue,
                                 input int gapMode, input int holdCycles,
                                 output longint total, output bit ovf);
        longint          modelAcc;
        bit              modelOvf;
        longint          chunkSum;
        logic [N*AW-1:0] data;
        logic [AW-1:0]   a;
        int              waitCount;
        modelAcc = 0;
        modelOvf = 1'b0;
        total    = 0;
        ovf      = 1'b0;
        data     = '0;
        @(negedge clock);
        startIn     = 1'b1;
        numChunksIn = CW'(nChunks);
        @(negedge clock);
        startIn = 1'b0;
        checkOutput("busyAfterStart", longint'(busyOut), 1);
        for (int c = 0; c < nChunks; c++) begin
            chunkSum = 0;
            for (int i = 0; i < N; i++) begin
                a = randomFill ? AW'($urandom) : AW'(fillValue);
                data[i*AW +: AW] = a;
                chunkSum += longint'($signed(a));
            end
            chunkDataIn  = data;
            chunkValidIn = 1'b1;
            waitCount    = 0;
            while (!chunkReadyOut && waitCount < 50) begin
                @(negedge clock);
                waitCount++;
            end
            if (!chunkReadyOut) begin
                checkOutput("chunkReadyTimeout", 0, 1);
                chunkValidIn = 1'b0;
                return;
            end
            @(negedge clock);
            chunkValidIn = 1'b0;
            modelAcc += chunkSum;
            if (modelAcc > ACC_MAX || modelAcc < ACC_MIN) begin
                modelOvf = 1'b1;
`ifdef ADDER_TREE_SATURATE_EN
                modelAcc = (modelAcc > ACC_MAX) ? ACC_MAX : ACC_MIN;
`else
                modelAcc = (modelAcc > ACC_MAX) ? modelAcc - ACC_SPAN : modelAcc + ACC_SPAN;
`endif
            end
            checkOutput("treeAddends", longint'(treeAddendsOut == data), 1);
            if (c < nChunks - 1 && (gapMode == 1 || (gapMode == 2 && $urandom_range(0, 1) == 1))) begin
                chunkDataIn = ~data;
                @(negedge clock);
                checkOutput("addendsHold", longint'(treeAddendsOut == data), 1);
            end
        end
        if (nChunks > 0) begin
            checkOutput("validInDrain", longint'(resultValidOut), 0);
            @(negedge clock);
        end else begin
            checkOutput("noReadyZeroJob", longint'(chunkReadyOut), 0);
        end
        checkOutput("resultValid", longint'(resultValidOut), 1);
        checkOutput("result", longint'($signed(resultOut)), modelAcc);
        checkOutput("overflow", longint'(overflowOut), longint'(modelOvf));
        for (int h = 0; h < holdCycles; h++) begin
            startIn     = (h == 2);
            numChunksIn = CW'(5);
            @(negedge clock);
            startIn = 1'b0;
            checkOutput("resultStable", longint'($signed(resultOut)), modelAcc);
            checkOutput("validHeld", longint'(resultValidOut), 1);
        end
        resultReadyIn = 1'b1;
        @(negedge clock);
        resultReadyIn = 1'b0;
        checkOutput("idleAfterHandshake", longint'(busyOut), 0);
        checkOutput("validDropped", longint'(resultValidOut), 0);
        checkOutput("resultKept", longint'($signed(resultOut)), modelAcc);
        checkOutput("overflowKept", longint'(overflowOut), longint'(modelOvf));
        total = modelAcc;
        ovf   = modelOvf;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        longint tot;
        bit     ov;

        #12;
        checkOutput("resetBusy", longint'(busyOut), 0);
        checkOutput("resetReady", longint'(chunkReadyOut), 0);
        checkOutput("resetValid", longint'(resultValidOut), 0);
        checkOutput("resetResult", longint'(resultOut), 0);
        checkOutput("resetOverflow", longint'(overflowOut), 0);
        @(negedge clock);
        resetN = 1'b1;

        applyStimulus(3, 1'b0, 1, 0, 0, tot, ov);
        checkOutput("case1Result", tot, 192);
        checkOutput("case1Overflow", longint'(ov), 0);

        applyStimulus(0, 1'b0, 0, 0, 0, tot, ov);
        checkOutput("case2Result", tot, 0);

        applyStimulus(4, 1'b0, -2, 1, 0, tot, ov);
        checkOutput("case3Result", tot, -512);

        applyStimulus(2, 1'b0, 32767, 0, 0, tot, ov);
`ifdef ADDER_TREE_SATURATE_EN
        checkOutput("case4Result", tot, 2097151);
`else
        checkOutput("case4Result", tot, -128);
`endif
        checkOutput("case4Overflow", longint'(ov), 1);

        // Abandon a five-chunk job after two transfers.
        @(negedge clock);
        startIn     = 1'b1;
        numChunksIn = CW'(5);
        @(negedge clock);
        startIn = 1'b0;
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < N; i++) chunkDataIn[i*AW +: AW] = AW'(1);
            chunkValidIn = 1'b1;
            @(negedge clock);
        end
        chunkValidIn = 1'b0;
        #2;
        resetN = 1'b0;
        #1;
        checkOutput("midResetBusy", longint'(busyOut), 0);
        checkOutput("midResetReady", longint'(chunkReadyOut), 0);
        checkOutput("midResetValid", longint'(resultValidOut), 0);
        checkOutput("midResetResult", longint'(resultOut), 0);
        checkOutput("midResetOverflow", longint'(overflowOut), 0);
        checkOutput("midResetAddends", longint'(treeAddendsOut == '0), 1);
        @(negedge clock);
        resetN = 1'b1;
        @(negedge clock);
        checkOutput("postResetIdle", longint'(busyOut), 0);
        checkOutput("postResetValid", longint'(resultValidOut), 0);
        applyStimulus(1, 1'b0, 1, 0, 0, tot, ov);
        checkOutput("case5Result", tot, 64);

        applyStimulus(2, 1'b1, 0, 0, 10, tot, ov);

        for (int j = 0; j < 12; j++) begin
            applyStimulus($urandom_range(0, 6), 1'b1, 0, 2, $urandom_range(0, 4), tot, ov);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adder_tree_sequencer.md
ADDER_TREE_SEQUENCER -- requirements
Module: adder_tree_sequencer

Interface
REQ-001 Parameter ADDEND_WIDTH, default 16, SHALL set the signed two's-complement width of each addend.
REQ-002 Parameter NUMBER_OF_ADDENDS, default 64, SHALL set addends per chunk; it SHALL be a power of two.
REQ-003 Parameter SUM_WIDTH, default ADDEND_WIDTH+$clog2(NUMBER_OF_ADDENDS), SHALL set the width of the tree sum.
REQ-004 Parameter ACC_WIDTH, default 32, SHALL set the accumulator and result width; ACC_WIDTH >= SUM_WIDTH.
REQ-005 Parameter CHUNK_CNT_WIDTH, default 8, SHALL set the width of the chunk count.
REQ-006 clk_in  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-007 rst_n_in  input  1  SHALL be the asynchronous, active-low reset.
REQ-008 start_in  input  1  SHALL request a new accumulation job.
REQ-009 num_chunks_in  input  CHUNK_CNT_WIDTH  SHALL give the number of chunks in the job, sampled with start_in.
REQ-010 busy_out  output  1  SHALL be high in every state except IDLE.
REQ-011 chunk_valid_in / chunk_ready_out  input / output  1 each  SHALL form the chunk handshake.
REQ-012 chunk_data_in  input  NUMBER_OF_ADDENDS*ADDEND_WIDTH  SHALL carry one chunk of addends.
REQ-013 tree_addends_out  output  NUMBER_OF_ADDENDS*ADDEND_WIDTH  SHALL drive the external combinational adder tree.
REQ-014 tree_sum_in  input  SUM_WIDTH  SHALL receive the signed tree sum of tree_addends_out in the same cycle.
REQ-015 result_valid_out / result_ready_in  output / input  1 each  SHALL form the result handshake.
REQ-016 result_out  output  ACC_WIDTH  SHALL carry the signed job total.
REQ-017 overflow_out  output  1  SHALL be a sticky per-job flag set on any accumulator signed overflow.

Function
REQ-018 States SHALL be IDLE, RUN, DRAIN and DONE.
REQ-019 IDLE: start_in high SHALL latch num_chunks_in into the remaining counter, clear the accumulator and overflow_out, and transition to RUN (or to DONE when num_chunks_in = 0).
REQ-020 start_in SHALL be ignored in every state other than IDLE.
REQ-021 chunk_ready_out SHALL be high only in RUN; a chunk transfer occurs when chunk_valid_in and chunk_ready_out are both high on a rising edge.
REQ-022 On a transfer, tree_addends_out SHALL register chunk_data_in and the remaining counter SHALL decrement by one; tree_addends_out SHALL otherwise hold its value.
REQ-023 The edge after a transfer SHALL add sign-extended tree_sum_in to the accumulator; one chunk per cycle SHALL be sustainable.
REQ-024 The transfer that takes remaining to 0 SHALL move RUN to DRAIN; DRAIN SHALL perform the final accumulate and move to DONE on the next edge.
REQ-025 Gaps in chunk_valid_in SHALL not corrupt the total; no accumulate SHALL occur for a cycle without a preceding transfer.
REQ-026 result_valid_out SHALL be high only in DONE, two cycles after the last chunk transfer; result_out SHALL equal the accumulator and remain stable until the handshake completes.
REQ-027 A result handshake SHALL return the state to IDLE on the same edge; result_out and overflow_out SHALL hold their values until the next accepted start_in.
REQ-028 Signed overflow on an accumulate SHALL set overflow_out; without ADDER_TREE_SATURATE_EN the accumulator SHALL wrap modulo 2^ACC_WIDTH.

Reset
REQ-029 While rst_n_in is low, the state SHALL be IDLE, and every output, the accumulator and the counters SHALL be zero, independent of clk_in.
REQ-030 Reset asserted mid-job SHALL abandon the job; after release, no stale result SHALL be presented.

Configuration
REQ-031 With macro ADDER_TREE_SATURATE_EN defined, an overflowing accumulate SHALL clamp to the most positive or most negative ACC_WIDTH value, set overflow_out, and continue from the clamped value; without the macro, REQ-028 wrap behaviour SHALL apply.

Verification
REQ-032 Case 1: num_chunks=3, chunks of all +1 back-to-back -> result_out=192, result_valid_out 2 cycles after the third transfer, overflow_out=0.
REQ-033 Case 2: num_chunks=0 -> DONE one cycle after start, result_out=0, chunk_ready_out never high.
REQ-034 Case 3: num_chunks=4, addends all -2, chunk_valid_in deasserted every other cycle -> result_out=-512.
REQ-035 Case 4: ACC_WIDTH=SUM_WIDTH=22, 2 chunks of all 32767 -> overflow_out=1; result wraps, or saturates to 2097151 with ADDER_TREE_SATURATE_EN.
REQ-036 Case 5: rst_n_in pulsed low after 2 of 5 chunks -> all outputs 0 asynchronously, IDLE after release; a following 1-chunk job of all +1 -> result_out=64.
REQ-037 Case 6: result_ready_in held low 10 cycles, start_in pulsed meanwhile -> result_out stable, start ignored, IDLE on handshake.
